apb_wait_slave: RTL

- APB completer (responder) with a word-addressed register memory, programmable wait states and error response.
- Sits at the target end of the APB bus: the initiator drives Pselx/Penable/Pwrite/Paddr/Pwdata, and this block answers with Pready/Pslverr/Prdata.
- Serves as the bus-side memory model and as the reusable peripheral front-end for later register blocks.

---
 rtl/apb_wait_slave.sv | 90 +++++++++
 1 files changed

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB completer with word-addressed register memory, programmable wait states and error response.
module apb_wait_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pwdata,
  output logic              Pready,
  output logic              Pslverr,
  output logic [DATA_W-1:0] Prdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q, addr_n, la;
  logic wr_q, wr_n, lw, setup, load, we, rdy_n, err_n;
  logic [3:0] cnt, cnt_n;
  logic [DATA_W-1:0] rdata_n;
  // A setup phase is honoured in either state; in ACCESS it restarts the transfer.
  always_comb begin
    setup   = Pselx & ~Penable;
    la      = setup ? Paddr : addr_q;
    lw      = setup ? Pwrite : wr_q;
    state_n = state;
    addr_n  = addr_q;
    wr_n    = wr_q;
    cnt_n   = cnt;
    rdy_n   = Pready;
    err_n   = Pslverr;
    rdata_n = Prdata;
    load    = 1'b0;
    we      = 1'b0;
    if (setup) begin
      state_n = ACCESS;
      addr_n  = Paddr;
      wr_n    = Pwrite;
      cnt_n   = 4'(WAIT_CYCLES);
      rdy_n   = 1'b0;
      err_n   = 1'b0;
      rdata_n = '0;
      load    = WAIT_CYCLES == 0;
    end else if (state == ACCESS) begin
      if (Pselx && !Pready) begin
        cnt_n = cnt - 4'(cnt != 4'd0);
        load  = cnt <= 4'd1;
      end else begin
        state_n = IDLE;
        rdy_n   = 1'b0;
        err_n   = 1'b0;
        rdata_n = '0;
        we      = Pselx && wr_q && addr_q < LIM;
      end
    end
    if (load) begin
      rdy_n   = 1'b1;
      err_n   = la >= LIM;
      rdata_n = (!lw && la < LIM) ? mem[la[IW-1:0]] : '0;
    end
  end
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      cnt     <= '0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      wr_q    <= wr_n;
      cnt     <= cnt_n;
      Pready  <= rdy_n;
      Pslverr <= err_n;
      Prdata  <= rdata_n;
      if (we) mem[addr_q[IW-1:0]] <= Pwdata;
    end
  end
endmodule
